// File: rtl/sd_to_binary_conv_hd_if.sv
// -----------------------------------------------------------------------------
// sd_to_binary_conv_hd_if
//
// Purpose: groups the two handshake buses of the signed-digit-to-binary
// converter.
//   - Digit stream, from the online divider into the converter:
//       q_value, data_out_vld, data_out_rdy
//   - Result word, from the converter to the consuming datapath:
//       q_word, q_word_vld, q_word_rdy
//
// Modports:
//   master : converter side. It accepts digits and produces q_word.
//   slave  : environment side. It drives digits and consumes q_word.
//
// Parameter:
//   PRECISION : quotient digits per frame. q_word is PRECISION+1 bits wide.
// -----------------------------------------------------------------------------
interface sd_to_binary_conv_hd_if #(
  parameter int PRECISION = 32
);

  logic [1:0]         q_value;       // signed digit: 10 = +1, 01 = -1, 00 = 0
  logic               data_out_vld;  // divider is presenting a digit
  logic               data_out_rdy;  // converter accepts a digit
  logic [PRECISION:0] q_word;        // two's-complement quotient
  logic               q_word_vld;    // q_word is valid
  logic               q_word_rdy;    // consumer takes q_word

  modport master (
    input  q_value,
    input  data_out_vld,
    output data_out_rdy,
    output q_word,
    output q_word_vld,
    input  q_word_rdy
  );

  modport slave (
    output q_value,
    output data_out_vld,
    input  data_out_rdy,
    input  q_word,
    input  q_word_vld,
    output q_word_rdy
  );

endinterface : sd_to_binary_conv_hd_if

// File: rtl/sd_to_binary_conv_hd.sv
// -----------------------------------------------------------------------------
// sd_to_binary_conv_hd
//
// Purpose: on-the-fly conversion of an MSD-first radix-2 signed-digit quotient
// stream into a two's-complement word. Two registers are kept, Q and QM, with
// the invariant QM = Q - 1. Each digit selects one of them as its shift
// source, so no carry-propagate add is needed when the frame ends.
//
// Ports:
//   clk        : clock
//   asyn_reset : synchronous, active-high reset. It is sampled only on the
//                rising edge of clk; the name is historical.
//   bus        : sd_to_binary_conv_hd_if.master. Carries the digit stream
//                (q_value / data_out_vld / data_out_rdy) and the result port
//                (q_word / q_word_vld / q_word_rdy).
//   digit_cnt  : number of digits accepted in the current frame.
//   digit_err  : sticky flag for an illegal 2'b11 digit.
//
// Parameters:
//   PRECISION : digits per frame, 2..127.
//   CNT_WIDTH : digit counter width. Must satisfy 2**CNT_WIDTH > PRECISION.
//
// Optional feature:
//   SD_CONV_DIGIT_CHK_EN : when defined, a transferred 2'b11 digit sets
//   digit_err. The flag clears on the q_word handshake or on reset. When
//   undefined, digit_err is tied low. In both builds 2'b11 converts as 0.
// -----------------------------------------------------------------------------
module sd_to_binary_conv_hd #(
  parameter int PRECISION = 32,
  parameter int CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  sd_to_binary_conv_hd_if.master bus,
  output logic [CNT_WIDTH-1:0] digit_cnt,
  output logic                 digit_err
);

  localparam int W = PRECISION + 1;
  localparam logic [CNT_WIDTH-1:0] FRAME_LEN = CNT_WIDTH'(PRECISION);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         q_q, q_d;
  logic [W-1:0]         qm_q, qm_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic digit_take;  // a digit transfers on this edge
  logic word_take;   // q_word is handed off on this edge

  // Readiness depends only on state. This keeps data_out_rdy free of any
  // combinational path from data_out_vld or q_word_rdy.
  assign digit_take = (state_q == COLLECT) && bus.data_out_vld;
  assign word_take  = (state_q == HOLD)    && bus.q_word_rdy;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch. An incomplete
    // branch then means "hold", not an inferred latch.
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      COLLECT: begin
        if (digit_take) begin
          // Both registers shift left. The digit picks the source and the
          // LSB, so QM = Q - 1 holds afterwards.
          case (bus.q_value)
            2'b10: begin  // +1
              q_d  = {q_q[W-2:0], 1'b1};
              qm_d = {q_q[W-2:0], 1'b0};
            end
            2'b01: begin  // -1
              q_d  = {qm_q[W-2:0], 1'b1};
              qm_d = {qm_q[W-2:0], 1'b0};
            end
            default: begin  // 0; the illegal 2'b11 is also converted as 0
              q_d  = {q_q[W-2:0], 1'b0};
              qm_d = {qm_q[W-2:0], 1'b1};
            end
          endcase
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == FRAME_LEN) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        // q_word is held until the consumer takes it. Then the next frame
        // starts from Q = 0, QM = -1. No digit is accepted on this edge.
        if (word_take) begin
          state_d = COLLECT;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge value, whatever the statement order.
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_q <= COLLECT;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.data_out_rdy = (state_q == COLLECT);
  assign bus.q_word_vld   = (state_q == HOLD);
  assign bus.q_word       = q_q;
  assign digit_cnt        = cnt_q;

`ifdef SD_CONV_DIGIT_CHK_EN
  logic err_q, err_d;

  // Sticky within a frame. It is cleared by the handshake that retires the
  // word it describes.
  always_comb begin
    err_d = err_q;
    if (word_take) begin
      err_d = 1'b0;
    end else if (digit_take && (bus.q_value == 2'b11)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign digit_err = err_q;
`else
  assign digit_err = 1'b0;
`endif

endmodule : sd_to_binary_conv_hd

// File: tb/tb_sd_to_binary_conv_hd.sv
// -----------------------------------------------------------------------------
// tb_sd_to_binary_conv_hd
//
// Self-checking bench for sd_to_binary_conv_hd with PRECISION = 8.
//
// Expected words are queued when a frame is driven. They are compared when
// the DUT hands off q_word. Inputs change 1 time unit after the rising edge;
// the monitor samples on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sd_to_binary_conv_hd;

  localparam int PREC  = 8;
  localparam int CW    = 7;
  localparam int WAIT_BUDGET = 50;

`ifdef SD_CONV_DIGIT_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [1:0] P = 2'b10;  // +1
  localparam logic [1:0] N = 2'b01;  // -1
  localparam logic [1:0] Z = 2'b00;  //  0
  localparam logic [1:0] X = 2'b11;  // illegal

  typedef struct {
    logic [2*PREC-1:0] digits;  // MSD in the top two bits
    logic [PREC:0]     word;    // expected q_word
    bit                bad;     // frame contains a 2'b11 digit
    bit                gap;     // insert an idle cycle after every digit
  } vec_t;

  typedef struct {
    logic [PREC:0] word;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic asyn_reset;
  logic [CW-1:0] digit_cnt;
  logic          digit_err;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sd_to_binary_conv_hd_if #(.PRECISION(PREC)) bus ();

  sd_to_binary_conv_hd #(
    .PRECISION(PREC),
    .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .asyn_reset(asyn_reset),
    .bus       (bus),
    .digit_cnt (digit_cnt),
    .digit_err (digit_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one digit and return after the edge that accepts it.
  task automatic send_digit(input logic [1:0] d);
    int waited = 0;
    bus.q_value      = d;
    bus.data_out_vld = 1'b1;
    while (!bus.data_out_rdy && waited < WAIT_BUDGET) begin
      tick();
      waited++;
    end
    if (!bus.data_out_rdy) begin
      n_checks++;
      n_errors++;
      $display("FAIL digit_accept_timeout: data_out_rdy=0, expected 1 within %0d cycles", WAIT_BUDGET);
    end
    tick();
    bus.data_out_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [2*PREC-1:0] digits, input logic [PREC:0] word,
                            input bit bad, input bit gap);
    exp_t e;
    e.word = word;
    e.err  = bad && CHK_EN;
    sb.push_back(e);
    for (int i = 0; i < PREC; i++) begin
      send_digit(digits[2*PREC-1-2*i -: 2]);
      if (gap && i != PREC - 1) begin
        tick();
        check("idle_keeps_cnt", 32'(digit_cnt), i + 1);
      end
    end
  endtask

  // Scoreboard monitor: compares each word handed off against the queue.
  always @(negedge clk) begin
    if (!asyn_reset && bus.q_word_vld && bus.q_word_rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %0h, expected no word", bus.q_word);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q_word", 32'(bus.q_word), 32'(e.word));
        check("digit_err_at_handshake", 32'(digit_err), 32'(e.err));
      end
    end
  end

  vec_t vecs[7];

  initial begin
    int waited;

    vecs[0] = '{{P, P, P, P, P, P, P, P}, 9'h0FF, 1'b0, 1'b0};  // +255/256
    vecs[1] = '{{N, N, N, N, N, N, N, N}, 9'h101, 1'b0, 1'b0};  // -255/256
    vecs[2] = '{{P, N, Z, Z, Z, Z, Z, P}, 9'h041, 1'b0, 1'b0};  // 65/256
    vecs[3] = '{{Z, Z, Z, Z, Z, Z, Z, N}, 9'h1FF, 1'b0, 1'b0};  // -1/256
    vecs[4] = '{{P, Z, N, Z, P, Z, N, Z}, 9'h066, 1'b0, 1'b1};  // 102/256, idles
    vecs[5] = '{{N, P, Z, Z, Z, Z, Z, Z}, 9'h1C0, 1'b0, 1'b0};  // -64/256
    vecs[6] = '{{P, P, X, P, P, P, P, P}, 9'h0DF, 1'b1, 1'b0};  // illegal digit 3

    bus.q_value      = 2'b00;
    bus.data_out_vld = 1'b0;
    bus.q_word_rdy   = 1'b1;
    asyn_reset       = 1'b1;
    tick();
    tick();
    asyn_reset = 1'b0;

    // Reset values
    check("rst_data_out_rdy", 32'(bus.data_out_rdy), 1);
    check("rst_q_word_vld",   32'(bus.q_word_vld),   0);
    check("rst_q_word",       32'(bus.q_word),       0);
    check("rst_digit_cnt",    32'(digit_cnt),        0);
    check("rst_digit_err",    32'(digit_err),        0);

    // Latency and single-cycle valid with q_word_rdy tied high
    send_frame(vecs[0].digits, vecs[0].word, vecs[0].bad, vecs[0].gap);
    check("vld_after_last_digit", 32'(bus.q_word_vld),   1);
    check("rdy_low_in_hold",      32'(bus.data_out_rdy), 0);
    tick();
    check("vld_one_cycle",        32'(bus.q_word_vld),   0);
    check("rdy_after_handshake",  32'(bus.data_out_rdy), 1);
    check("cnt_after_handshake",  32'(digit_cnt),        0);

    // Table-driven frames
    for (int v = 1; v < 7; v++) begin
      send_frame(vecs[v].digits, vecs[v].word, vecs[v].bad, vecs[v].gap);
    end
    tick();
    check("err_cleared_after_handshake", 32'(digit_err), 0);

    // Backpressure: the result is held while the digit source keeps vld high
    bus.q_word_rdy = 1'b0;
    send_frame(vecs[5].digits, vecs[5].word, 1'b0, 1'b0);
    bus.q_value      = P;
    bus.data_out_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_data_out_rdy", 32'(bus.data_out_rdy), 0);
      check("bp_q_word_vld",   32'(bus.q_word_vld),   1);
      check("bp_q_word",       32'(bus.q_word),       32'(vecs[5].word));
      tick();
    end
    bus.q_word_rdy = 1'b1;
    tick();
    // No digit is taken on the handshake edge.
    check("no_digit_on_handshake", 32'(digit_cnt), 0);
    check("rdy_after_release",     32'(bus.data_out_rdy), 1);
    bus.data_out_vld = 1'b0;
    send_frame({P, Z, Z, Z, Z, Z, Z, Z}, 9'h080, 1'b0, 1'b0);

    // Reset mid-frame, with a digit presented on the reset edge
    for (int i = 0; i < 4; i++) send_digit(P);
    check("partial_cnt", 32'(digit_cnt), 4);
    bus.q_value      = P;
    bus.data_out_vld = 1'b1;
    asyn_reset       = 1'b1;
    tick();
    asyn_reset       = 1'b0;
    bus.data_out_vld = 1'b0;
    check("midrst_cnt",    32'(digit_cnt),        0);
    check("midrst_q_word", 32'(bus.q_word),       0);
    check("midrst_rdy",    32'(bus.data_out_rdy), 1);
    check("midrst_vld",    32'(bus.q_word_vld),   0);
    send_frame({Z, Z, Z, Z, Z, Z, Z, Z}, 9'h000, 1'b0, 1'b0);

    // Drain the scoreboard
    waited = 0;
    while (sb.size() != 0 && waited < WAIT_BUDGET) begin
      tick();
      waited++;
    end
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sd_to_binary_conv_hd

// File: doc/sd_to_binary_conv_hd.md
# sd_to_binary_conv_hd

Downstream stage of the online divider. It takes the MSD-first radix-2 signed-digit quotient stream (`q_value`, `data_out_vld` / `data_out_rdy`) and converts it on the fly into a conventional two's-complement word. Per-digit Q/QM register updates remove any carry-propagate add at the end. A full-precision result is presented on a parallel valid/ready port for the consuming datapath.

## Interface
Parameters:
- `PRECISION`, default 32: quotient digits per frame, range 2–127.
- `CNT_WIDTH`, default 7: digit counter width; must satisfy 2^CNT_WIDTH > PRECISION.

Ports:
- `clk` in, 1: the single clock.
- `asyn_reset` in, 1: reset, synchronous and active-high. The name is kept for codebase consistency; it is sampled only on the rising edge of `clk`.
- `q_value` in, 2: signed quotient digit. `2'b10` = +1, `2'b01` = −1, `2'b00` = 0, `2'b11` is illegal.
- `data_out_vld` in, 1: the divider is presenting a digit.
- `data_out_rdy` out, 1: the converter accepts a digit this cycle.
- `q_word` out, PRECISION+1: two's-complement quotient, value = q_word·2^−PRECISION.
- `q_word_vld` out, 1: `q_word` is valid.
- `q_word_rdy` in, 1: the consumer takes `q_word`.
- `digit_cnt` out, CNT_WIDTH: number of digits accepted in the current frame.
- `digit_err` out, 1: sticky illegal-digit flag (see Configuration).

## Operation
- A digit transfers when `data_out_vld` and `data_out_rdy` are both 1 at a rising edge.
- Internal registers are Q and QM, each PRECISION+1 bits.
  - Frame start: Q = 0, QM = all ones (−1).
- Update on each transferred digit, with W = PRECISION+1-bit left shift:
  - +1: Q ← {Q[W−2:0],1}; QM ← {Q[W−2:0],0}
  - 0: Q ← {Q[W−2:0],0}; QM ← {QM[W−2:0],1}
  - −1: Q ← {QM[W−2:0],1}; QM ← {QM[W−2:0],0}
- Bits shifted out of the MSB are discarded. The invariant QM = Q − 1 holds after every digit.
- The FSM has two states, COLLECT (the reset state) and HOLD.
  - COLLECT: `data_out_rdy` = 1 and `q_word_vld` = 0. Every transfer increments `digit_cnt`.
  - COLLECT → HOLD: on the transfer that makes the count equal PRECISION.
  - HOLD: `data_out_rdy` = 0, `q_word_vld` = 1, and `q_word` = Q, held stable.
  - HOLD → COLLECT: when `q_word_rdy` = 1. On that edge, Q = 0, QM = all ones, `digit_cnt` = 0.
- `q_word_vld` must not drop, and `q_word` must not change, while the converter waits for `q_word_rdy`.
- `data_out_rdy` does not depend combinationally on `data_out_vld` or `q_word_rdy`; it is a pure function of state.
- The result range is [−(2^PRECISION−1), 2^PRECISION−1]. No overflow is possible.

## Timing
- Reset values: `data_out_rdy` = 1, `q_word_vld` = 0, `q_word` = 0, `digit_cnt` = 0, `digit_err` = 0, state = COLLECT.
- Throughput in COLLECT is one digit per cycle.
- Latency: `q_word_vld` rises on the edge after the PRECISION-th transfer, i.e. the edge that accepts digit PRECISION.
- Minimum frame period is PRECISION+1 cycles: PRECISION digits plus one HOLD cycle when `q_word_rdy` is tied to 1.
- Digits cannot be accepted in the same cycle as the `q_word` handshake. The first digit of the next frame is accepted one cycle after HOLD exits.
- Idle cycles in COLLECT (`data_out_vld` = 0) leave Q, QM and `digit_cnt` unchanged.
- Reset asserted mid-frame or in HOLD discards the partial or pending result on that edge and restores the reset values. Reset has priority over any simultaneous transfer.

## Configuration
Macro: `SD_CONV_DIGIT_CHK_EN`.
- Defined:
  - A transferred `2'b11` digit sets `digit_err` and is converted as 0.
  - `digit_err` stays set until the `q_word` handshake or reset clears it.
  - It is valid to read alongside `q_word` while `q_word_vld` = 1.
- Undefined:
  - `2'b11` is converted as 0 silently and `digit_err` is tied to 0.
  - The checking logic is not synthesised.

## Test plan
- PRECISION = 8, eight +1 digits back-to-back, `q_word_rdy` = 1 → `q_word` = 9'h0FF, `q_word_vld` high for exactly 1 cycle, 9 cycles per frame.
- PRECISION = 8, eight −1 digits → `q_word` = 9'h101 (−255).
- PRECISION = 8, digits +1, −1, 0, 0, 0, 0, 0, +1 (value 2^−2 + 2^−8 = 65/256) → `q_word` = 9'h041.
- Hold `q_word_rdy` = 0 for 5 cycles after completion while `data_out_vld` = 1 → `data_out_rdy` = 0 throughout, `q_word` stable. Release → next frame starts cleanly: first digit +1, rest 0 → 9'h080.
- Assert `asyn_reset` after 4 of 8 digits, then send a fresh 8-digit all-zero frame → `q_word` = 9'h000. No residue from the aborted frame.
- With `SD_CONV_DIGIT_CHK_EN` defined, inject `2'b11` as digit 3 of an otherwise all +1 frame → `digit_err` = 1 with `q_word` = 9'h0DF; cleared after the handshake.
